// File: rtl/seq_checker.sv
// seq_checker: tracks a symbol stream that steps through the cycle 2,3,5,7,10.
// The stream may step up or down through the cycle, and the block locks onto it.
// Once locked, it flags each mismatch. After MISS_LIMIT consecutive misses it
// drops lock and goes back to hunting.
// Optional feature: define SEQ_CHECKER_ERRCNT_EN to build the saturating
// mismatch counter on err_cnt. When the macro is undefined, err_cnt is tied to 0.
module seq_checker #(
    parameter int MISS_LIMIT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] seq_in,
    input  logic       seq_valid,
    output logic       locked,
    output logic       dir,
    output logic [2:0] idx,
    output logic       seq_err,
    output logic       dir_change,
    output logic [7:0] err_cnt
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] ref_q, ref_d;
    logic       dir_q, dir_d;
    logic [2:0] idx_q, idx_d;
    logic       seq_err_q, seq_err_d;
    logic       dir_change_q, dir_change_d;
    logic [1:0] miss_q, miss_d;

    logic       sym_legal;
    logic [2:0] sym_idx;
    logic [3:0] up_s;
    logic [3:0] dn_s;
    logic       is_up;
    logic       is_dn;

    function automatic logic is_legal(input logic [3:0] s);
        case (s)
            4'd0, 4'd2, 4'd3, 4'd5, 4'd7, 4'd10: is_legal = 1'b1;
            default:                             is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] sym_index(input logic [3:0] s);
        case (s)
            4'd2:    sym_index = 3'd1;
            4'd3:    sym_index = 3'd2;
            4'd5:    sym_index = 3'd3;
            4'd7:    sym_index = 3'd4;
            4'd10:   sym_index = 3'd5;
            default: sym_index = 3'd0;
        endcase
    endfunction

    // Symbol 0 is an entry point only: both of its successors are 2.
    function automatic logic [3:0] up_succ(input logic [3:0] s);
        case (s)
            4'd0:    up_succ = 4'd2;
            4'd2:    up_succ = 4'd3;
            4'd3:    up_succ = 4'd5;
            4'd5:    up_succ = 4'd7;
            4'd7:    up_succ = 4'd10;
            4'd10:   up_succ = 4'd2;
            default: up_succ = 4'd15;
        endcase
    endfunction

    function automatic logic [3:0] dn_succ(input logic [3:0] s);
        case (s)
            4'd0:    dn_succ = 4'd2;
            4'd2:    dn_succ = 4'd10;
            4'd3:    dn_succ = 4'd2;
            4'd5:    dn_succ = 4'd3;
            4'd7:    dn_succ = 4'd5;
            4'd10:   dn_succ = 4'd7;
            default: dn_succ = 4'd15;
        endcase
    endfunction

    // Classify the incoming symbol against the stored reference.
    always_comb begin
        sym_legal = is_legal(seq_in);
        sym_idx   = sym_index(seq_in);
        up_s      = up_succ(ref_q);
        dn_s      = dn_succ(ref_q);
        is_up     = (seq_in == up_s);
        is_dn     = (seq_in == dn_s);
    end

    // Next-state and registered-output values. Idle cycles hold everything.
    always_comb begin
        state_d      = state_q;
        ref_d        = ref_q;
        dir_d        = dir_q;
        idx_d        = idx_q;
        miss_d       = miss_q;
        seq_err_d    = 1'b0;
        dir_change_d = 1'b0;
        if (seq_valid) begin
            case (state_q)
                HUNT: begin
                    if (sym_legal) begin
                        ref_d   = seq_in;
                        idx_d   = sym_idx;
                        state_d = CHECK;
                    end
                end
                CHECK: begin
                    if (seq_in == ref_q) begin
                        state_d = CHECK;
                    end else if (is_up || is_dn) begin
                        // Up wins when both successors match (only from 0).
                        ref_d   = seq_in;
                        idx_d   = sym_idx;
                        dir_d   = is_up;
                        miss_d  = 2'd0;
                        state_d = LOCKED;
                    end else if (sym_legal && (seq_in != 4'd0)) begin
                        ref_d   = seq_in;
                        idx_d   = sym_idx;
                    end else begin
                        state_d = HUNT;
                    end
                end
                LOCKED: begin
                    if (seq_in == ref_q) begin
                        state_d = LOCKED;
                    end else if (is_up || is_dn) begin
                        ref_d        = seq_in;
                        idx_d        = sym_idx;
                        dir_d        = is_up;
                        dir_change_d = (is_up != dir_q);
                        miss_d       = 2'd0;
                    end else begin
                        seq_err_d = 1'b1;
                        if (int'(miss_q) + 1 >= MISS_LIMIT) begin
                            miss_d  = 2'd0;
                            state_d = HUNT;
                        end else begin
                            miss_d  = miss_q + 2'd1;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Tracker state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= HUNT;
            ref_q        <= 4'd0;
            dir_q        <= 1'b1;
            idx_q        <= 3'd0;
            miss_q       <= 2'd0;
            seq_err_q    <= 1'b0;
            dir_change_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ref_q        <= ref_d;
            dir_q        <= dir_d;
            idx_q        <= idx_d;
            miss_q       <= miss_d;
            seq_err_q    <= seq_err_d;
            dir_change_q <= dir_change_d;
        end
    end

`ifdef SEQ_CHECKER_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        sat_inc = (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Count mismatches, sticking at 255.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (seq_err_d) begin
            err_cnt_d = sat_inc(err_cnt_q);
        end
    end

    // Mismatch counter register, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'd0;
`endif

    assign locked     = (state_q == LOCKED);
    assign dir        = dir_q;
    assign idx        = idx_q;
    assign seq_err    = seq_err_q;
    assign dir_change = dir_change_q;

endmodule
